// File: rtl/mem_port_arbiter.sv
// Arbitrates one external memory port between the CPU memory stage and the DMA engine.
// CPU has priority; a saturating starvation counter forces a DMA grant after STARVE_LIMIT CPU wins.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_valid,
  output logic [DATA_W-1:0] dma_rdata,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              cpu_gnt,
  output logic              dma_gnt,
  output logic              err_spurious,
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic                grant_dma;
  logic                in_busy;
  logic                in_wait;
  logic                spurious;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= OWN_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    grant_dma = dma_req & (~cpu_req | (cnt_q >= LIMIT));

    case (state_q)
      S_IDLE: begin
        if (cpu_req | dma_req) begin
          state_d = S_ISSUE;
          if (grant_dma) begin
            owner_d = OWN_DMA;
            we_d    = dma_we;
            addr_d  = dma_addr;
            wdata_d = dma_wdata;
            cnt_d   = '0;
          end else begin
            owner_d = OWN_CPU;
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            // only a CPU win over a waiting DMA counts toward starvation
            if (dma_req && (cnt_q < LIMIT)) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_valid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_busy  = (state_q == S_ISSUE) | (state_q == S_WAIT);
  assign in_wait  = (state_q == S_WAIT);
  assign spurious = mem_valid & ~in_wait;
  assign err_d    = err_clr ? 1'b0 : (err_q | spurious);

  assign mem_req      = (state_q == S_ISSUE);
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign err_spurious = err_q;

  assign cpu_gnt   = in_busy & (owner_q == OWN_CPU);
  assign dma_gnt   = in_busy & (owner_q == OWN_DMA);
  assign cpu_valid = mem_valid & in_wait & (owner_q == OWN_CPU);
  assign dma_valid = mem_valid & in_wait & (owner_q == OWN_DMA);
  assign cpu_rdata = cpu_valid ? mem_rdata : '0;
  assign dma_rdata = dma_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_valid;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_valid;
  logic [DW-1:0] dma_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_valid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          cpu_gnt, dma_gnt, err_spurious;
  logic          err_clr = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_valid(dma_valid), .dma_rdata(dma_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt), .err_spurious(err_spurious), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  // Transaction model: one outstanding transfer, aged in cycles since its grant.
  bit          m_busy = 1'b0;
  int          m_age = 0;
  bit          m_dma = 1'b0;
  logic        m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  int          m_starve = 0;
  bit          m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit waiting;
    if (!rst_n) begin
      m_busy = 0; m_age = 0; m_dma = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      m_starve = 0; m_err = 0;
    end else begin
      waiting = m_busy && (m_age >= 1);
      m_err = err_clr ? 1'b0 : (m_err | (mem_valid && !waiting));
      if (!m_busy) begin
        if (cpu_req || dma_req) begin
          m_dma   = dma_req && (!cpu_req || (m_starve >= LIM));
          m_we    = m_dma ? dma_we : cpu_we;
          m_addr  = m_dma ? dma_addr : cpu_addr;
          m_wdata = m_dma ? dma_wdata : cpu_wdata;
          if (m_dma) m_starve = 0;
          else if (dma_req) m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
          m_busy = 1;
          m_age  = 0;
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (mem_valid) begin
        m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit waiting, ev_cpu, ev_dma;
    waiting = m_busy && (m_age >= 1);
    ev_cpu  = mem_valid && waiting && !m_dma;
    ev_dma  = mem_valid && waiting && m_dma;
    chk("mem_req",      DW'(mem_req),      DW'(m_busy && m_age == 0));
    chk("mem_we",       DW'(mem_we),       DW'(m_we));
    chk("mem_addr",     mem_addr,          m_addr);
    chk("mem_wdata",    mem_wdata,         m_wdata);
    chk("cpu_gnt",      DW'(cpu_gnt),      DW'(m_busy && !m_dma));
    chk("dma_gnt",      DW'(dma_gnt),      DW'(m_busy && m_dma));
    chk("cpu_valid",    DW'(cpu_valid),    DW'(ev_cpu));
    chk("dma_valid",    DW'(dma_valid),    DW'(ev_dma));
    chk("cpu_rdata",    cpu_rdata,         ev_cpu ? mem_rdata : '0);
    chk("dma_rdata",    dma_rdata,         ev_dma ? mem_rdata : '0);
    chk("err_spurious", DW'(err_spurious), DW'(m_err));
  end

  // One-cycle memory responder and grant-order recorder for the contention scenario.
  bit auto_mem = 1'b0;
  bit rec = 1'b0;
  bit gq[$];
  int rd_cnt = 0;

  always @(posedge clk) begin
    logic rq;
    rq = mem_req;
    #1;
    if (auto_mem) begin
      mem_valid = rq;
      mem_rdata = rq ? (32'hA000_0000 + rd_cnt) : '0;
      rd_cnt++;
    end
  end

  always @(negedge clk) if (rec && mem_req) gq.push_back(dma_gnt);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    bit exp_order [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // reset state
    at_neg();
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_err", DW'(err_spurious), '0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: CPU read
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100; cpu_wdata = 32'h55;
    tick();
    at_neg();
    chk("t1_mem_req", DW'(mem_req), 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_cpu_gnt", DW'(cpu_gnt), 1);
    tick(); tick(); tick();
    mem_valid = 1; mem_rdata = 32'hDEADBEEF;
    at_neg();
    chk("t1_cpu_valid", DW'(cpu_valid), 1);
    chk("t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("t1_dma_valid", DW'(dma_valid), 0);
    tick();
    cpu_req = 0; mem_valid = 0; mem_rdata = '0;

    // 2: DMA write
    dma_req = 1; dma_we = 1; dma_addr = 32'h200; dma_wdata = 32'h1234;
    tick();
    at_neg();
    chk("t2_mem_we", DW'(mem_we), 1);
    chk("t2_mem_wdata", mem_wdata, 32'h1234);
    chk("t2_dma_gnt", DW'(dma_gnt), 1);
    tick();
    mem_valid = 1;
    at_neg();
    chk("t2_dma_valid", DW'(dma_valid), 1);
    chk("t2_cpu_valid", DW'(cpu_valid), 0);
    chk("t2_wait_wdata", mem_wdata, 32'h1234);
    chk("t2_wait_we", DW'(mem_we), 1);
    tick();
    dma_req = 0; dma_we = 0; mem_valid = 0;

    // 3: contention with continuous requests and 1-cycle memory
    cpu_req = 1; cpu_addr = 32'h400;
    dma_req = 1; dma_we = 1; dma_addr = 32'h500; dma_wdata = 32'h77;
    auto_mem = 1; rec = 1;
    repeat (17) tick();
    cpu_req = 0; dma_req = 0;
    repeat (3) tick();
    auto_mem = 0; rec = 0;
    mem_valid = 0; mem_rdata = '0;
    chk("t3_grants", gq.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t3_order%0d", i), (i < gq.size()) ? DW'(gq[i]) : 32'hFFFF_FFFF, DW'(exp_order[i]));

    // 4: input changes ignored after grant
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    tick(); tick();
    cpu_addr = 32'h300;
    at_neg();
    chk("t4_hold_a", mem_addr, 32'h100);
    tick();
    mem_valid = 1; mem_rdata = 32'hCAFE;
    at_neg();
    chk("t4_hold_b", mem_addr, 32'h100);
    chk("t4_cpu_valid", DW'(cpu_valid), 1);
    tick();
    cpu_req = 0; mem_valid = 0; mem_rdata = '0;

    // 5: spurious completion in IDLE
    mem_valid = 1;
    at_neg();
    chk("t5_no_cpu_valid", DW'(cpu_valid), 0);
    chk("t5_no_dma_valid", DW'(dma_valid), 0);
    tick();
    mem_valid = 0;
    at_neg();
    chk("t5_err_set", DW'(err_spurious), 1);
    tick();
    err_clr = 1;
    at_neg();
    chk("t5_err_sticky", DW'(err_spurious), 1);
    tick();
    err_clr = 0;
    at_neg();
    chk("t5_err_clr", DW'(err_spurious), 0);

    // 6: reset mid-WAIT, late completion, then a normal read
    tick();
    cpu_req = 1; cpu_addr = 32'h600;
    tick(); tick(); tick();
    rst_n = 0; cpu_req = 0;
    #1;
    chk("t6_rst_gnt", DW'(cpu_gnt), 0);
    chk("t6_rst_addr", mem_addr, '0);
    chk("t6_rst_req", DW'(mem_req), 0);
    tick();
    rst_n = 1;
    tick();
    mem_valid = 1;
    at_neg();
    chk("t6_late_no_valid", DW'(cpu_valid), 0);
    tick();
    mem_valid = 0;
    at_neg();
    chk("t6_late_err", DW'(err_spurious), 1);
    tick();
    err_clr = 1;
    tick();
    err_clr = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    tick();
    at_neg();
    chk("t6_mem_req", DW'(mem_req), 1);
    chk("t6_mem_addr", mem_addr, 32'h100);
    tick();
    mem_valid = 1; mem_rdata = 32'h0BADF00D;
    at_neg();
    chk("t6_cpu_valid", DW'(cpu_valid), 1);
    chk("t6_cpu_rdata", cpu_rdata, 32'h0BADF00D);
    tick();
    cpu_req = 0; mem_valid = 0; mem_rdata = '0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
